// File: rtl/imm_extend_unit_pkg.sv
// Shared encodings for the immediate-generation stage: operand modes and
// the prefix FSM states.
package imm_extend_unit_pkg;

  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
  localparam logic [1:0] MODE_PREFIX   = 2'b11;

  typedef enum logic {
    ST_NOPRE = 1'b0,
    ST_PRE   = 1'b1
  } state_e;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Request/response bundle between decode (master) and the immediate unit (slave).
interface imm_extend_unit_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [1:0]       mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic             prefix_pending;

  modport master (
    output in_valid, imm_in, mode, flush, out_ready,
    input  in_ready, out_valid, imm_out, prefix_pending
  );

  modport slave (
    input  in_valid, imm_in, mode, flush, out_ready,
    output in_ready, out_valid, imm_out, prefix_pending
  );

endinterface

// File: rtl/imm_extend_unit_core.sv
// Combinational width arithmetic: sign/zero extension, scaling, and
// concatenation with a latched prefix.
module imm_extend_unit_core
  import imm_extend_unit_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 1,
  localparam int unsigned PRE_W = OUT_W - IN_W
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  input  logic [PRE_W-1:0] prefix_i,
  input  logic             prefix_valid_i,
  output logic [OUT_W-1:0] value_o
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] base;

  assign sext = {{PRE_W{imm_i[IN_W-1]}}, imm_i};
  assign zext = {{PRE_W{1'b0}}, imm_i};
  assign base = {prefix_i, imm_i};

  always_comb begin
    value_o = sext;
    if (prefix_valid_i) begin
      // A prefixed immediate is never extended; only the scale applies.
      value_o = (mode_i == MODE_SEXT_SHL) ? (base << SHIFT) : base;
    end else begin
      case (mode_i)
        MODE_SEXT:     value_o = sext;
        MODE_ZEXT:     value_o = zext;
        MODE_SEXT_SHL: value_o = sext << SHIFT;
        default:       value_o = sext;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate-generation stage: prefix FSM, prefix register and a single
// registered valid/ready output slot.
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 1
) (
  input logic               clk,
  input logic               rst_n,
  imm_extend_unit_if.slave  bus
);

  localparam int unsigned PRE_W = OUT_W - IN_W;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] prefix_q, prefix_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] imm_q, imm_d;
  logic [OUT_W-1:0] ext_value;
  logic             accept;

  imm_extend_unit_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm_i          (bus.imm_in),
    .mode_i         (bus.mode),
    .prefix_i       (prefix_q),
    .prefix_valid_i (state_q == ST_PRE),
    .value_o        (ext_value)
  );

  assign bus.in_ready       = !out_valid_q || bus.out_ready;
  assign accept             = bus.in_valid && bus.in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.imm_out        = imm_q;
  assign bus.prefix_pending = (state_q == ST_PRE);

  always_comb begin
    state_d     = state_q;
    prefix_d    = prefix_q;
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // Flush outranks any same-cycle request, which is simply dropped.
    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_NOPRE;
    end else if (accept) begin
      if (bus.mode == MODE_PREFIX) begin
        prefix_d = bus.imm_in[PRE_W-1:0];
        state_d  = ST_PRE;
      end else begin
        imm_d       = ext_value;
        out_valid_d = 1'b1;
        state_d     = ST_NOPRE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_NOPRE;
      prefix_q    <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      prefix_q    <= prefix_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: arithmetic reference model checked every
// cycle, plus literal expectations on each directed transaction.
module tb_imm_extend_unit;

  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int SHIFT = 1;
  localparam int PRE_W = OUT_W - IN_W;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  bit   run_cmp;

  imm_extend_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_extend_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operand value from plain integer arithmetic.
  function automatic int model_val(input int m, input int imm, input int pre, input bit pend);
    int v;
    if (pend)        v = pre * (1 << IN_W) + imm;
    else if (m == 1) v = imm;
    else             v = (imm >= (1 << (IN_W - 1))) ? imm - (1 << IN_W) : imm;
    if (m == 2) v = v * (1 << SHIFT);
    return v & ((1 << OUT_W) - 1);
  endfunction

  int m_valid, m_imm, m_pre, m_pend;

  always @(posedge clk) begin
    int rdy;
    rdy = (!m_valid || bus.out_ready) ? 1 : 0;
    if (!rst_n) begin
      m_valid = 0; m_imm = 0; m_pre = 0; m_pend = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_pend = 0;
    end else begin
      if (m_valid != 0 && bus.out_ready) m_valid = 0;
      if (bus.in_valid && rdy != 0) begin
        if (bus.mode == 2'b11) begin
          m_pre  = int'(bus.imm_in) % (1 << PRE_W);
          m_pend = 1;
        end else begin
          m_imm   = model_val(int'(bus.mode), int'(bus.imm_in), m_pre, m_pend != 0);
          m_valid = 1;
          m_pend  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("prefix_pending", 32'(bus.prefix_pending), 32'(m_pend));
      chk("in_ready", 32'(bus.in_ready), 32'((!m_valid || bus.out_ready) ? 1 : 0));
      if (m_valid != 0) chk("imm_out", 32'(bus.imm_out), 32'(m_imm));
    end
  end

  // Called at posedge+1; returns at posedge+1 after checking at the negedge.
  task automatic issue(input logic [1:0] m, input logic [IN_W-1:0] imm,
                       input bit is_data, input logic [OUT_W-1:0] exp);
    bus.in_valid = 1'b1; bus.mode = m; bus.imm_in = imm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (is_data) begin
      chk("lit_valid", 32'(bus.out_valid), 32'd1);
      chk("lit_imm", 32'(bus.imm_out), 32'(exp));
      chk("lit_nopend", 32'(bus.prefix_pending), 32'd0);
    end else begin
      chk("lit_pend", 32'(bus.prefix_pending), 32'd1);
      chk("lit_noout", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic kill(input bit use_rst);
    bus.in_valid = 1'b1; bus.mode = 2'b00; bus.imm_in = 12'h456;
    if (use_rst) rst_n = 1'b0; else bus.flush = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("kill_valid", 32'(bus.out_valid), 32'd0);
    chk("kill_pend", 32'(bus.prefix_pending), 32'd0);
    if (use_rst) chk("kill_imm", 32'(bus.imm_out), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic kill_seq(input bit use_rst);
    bus.out_ready = 1'b0;
    issue(2'b00, 12'h0FF, 1'b1, 16'h00FF);
    kill(use_rst);
    bus.out_ready = 1'b1;
    issue(2'b11, 12'h00A, 1'b0, 16'h0000);
    kill(use_rst);
    issue(2'b00, 12'h123, 1'b1, 16'h0123);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; run_cmp = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.imm_in = '0; bus.mode = 2'b00;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", 32'(bus.imm_out), 32'd0);
    chk("rst_pend", 32'(bus.prefix_pending), 32'd0);
    run_cmp = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 12'h800, 1'b1, 16'hF800);
    issue(2'b01, 12'h800, 1'b1, 16'h0800);
    issue(2'b10, 12'h800, 1'b1, 16'hF000);
    issue(2'b10, 12'h801, 1'b1, 16'hF002);
    issue(2'b10, 12'h7FF, 1'b1, 16'h0FFE);
    issue(2'b00, 12'h000, 1'b1, 16'h0000);
    issue(2'b01, 12'hFFF, 1'b1, 16'h0FFF);

    issue(2'b11, 12'h00A, 1'b0, 16'h0000);
    issue(2'b00, 12'h123, 1'b1, 16'hA123);
    issue(2'b11, 12'h00A, 1'b0, 16'h0000);
    issue(2'b11, 12'h005, 1'b0, 16'h0000);
    issue(2'b10, 12'h800, 1'b1, 16'hB000);
    issue(2'b11, 12'hFFC, 1'b0, 16'h0000);
    issue(2'b01, 12'hFFF, 1'b1, 16'hCFFF);

    // Back-to-back accepts with the slot consumed every cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mode = 2'(i % 3); bus.imm_in = 12'(12'h7F0 + i * 12'h111);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: held result, queued request accepted as out_ready rises.
    bus.out_ready = 1'b0;
    issue(2'b00, 12'h0FF, 1'b1, 16'h00FF);
    bus.in_valid = 1'b1; bus.mode = 2'b01; bus.imm_in = 12'h855;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold", 32'(bus.imm_out), 32'h00FF);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_up", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new", 32'(bus.imm_out), 32'h0855);
    chk("bp_new_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    kill_seq(1'b0);
    kill_seq(1'b1);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
